// File: rtl/npxl_bar_controller.sv
// WS2812 level-meter driver: renders a green/yellow/red bar or dot with optional
// peak-hold marker and shifts it out as one GRB frame per accepted request.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | o_rdy high, waiting for i_send
// LOAD  | build the GRB word for pixel idx, bit index = 23
// HIGH  | data high for T0H/T1H clocks depending on the current bit
// LOW   | data low until the bit period (measured from the rise) ends
// LATCH | data low for TLATCH_CYC clocks so the strip latches
module npxl_bar_controller #(
    parameter int         LEDS       = 20,
    parameter int         ADDR       = 8,
    parameter int         T0H_CYC    = 20,
    parameter int         T1H_CYC    = 40,
    parameter int         TBIT_CYC   = 63,
    parameter int         TLATCH_CYC = 3000,
    parameter int         YEL_START  = 12,
    parameter int         RED_START  = 16,
    parameter logic [7:0] BRIGHT     = 8'h20,
    parameter int         PEAK_HOLD  = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_send,
    input  logic [ADDR-1:0] i_value,
    input  logic            i_dot_mode,
    input  logic            i_peak_en,
    output logic            o_npxl_data,
    output logic            o_rdy
);

    localparam int TMAX = (TLATCH_CYC > TBIT_CYC) ? TLATCH_CYC : TBIT_CYC;
    localparam int TW   = $clog2(TMAX);
    localparam int HW   = $clog2(PEAK_HOLD + 1);

    localparam logic [TW-1:0]   TBIT_LD   = TW'(TBIT_CYC - 1);
    localparam logic [TW-1:0]   TLATCH_LD = TW'(TLATCH_CYC - 1);
    localparam logic [TW-1:0]   T0H_END   = TW'(TBIT_CYC - T0H_CYC);
    localparam logic [TW-1:0]   T1H_END   = TW'(TBIT_CYC - T1H_CYC);
    localparam logic [ADDR-1:0] LEDS_A    = ADDR'(LEDS);
    localparam logic [ADDR-1:0] LAST_IDX  = ADDR'(LEDS - 1);
    localparam logic [ADDR-1:0] YEL_A     = ADDR'(YEL_START);
    localparam logic [ADDR-1:0] RED_A     = ADDR'(RED_START);
    localparam logic [HW-1:0]   HOLD_MAX  = HW'(PEAK_HOLD);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HIGH,
        LOW,
        LATCH
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [TW-1:0]   tmr;
    logic [4:0]      bit_idx;
    logic [23:0]     shreg;
    logic [ADDR-1:0] idx;
    logic [ADDR-1:0] lvl_q;
    logic            dot_q;
    logic            pe_q;
    logic [ADDR-1:0] peak;
    logic [HW-1:0]   hold;
    logic            data_q;
    logic            rdy_q;

    logic [ADDR-1:0] lvl_in;
    logic [ADDR-1:0] peak_nxt;
    logic [HW-1:0]   hold_nxt;
    logic [TW-1:0]   high_end;
    logic [23:0]     zone_rgb;
    logic            lit;
    logic            peak_hit;
    logic [23:0]     pix_word;

    assign lvl_in      = (i_value > LEDS_A) ? LEDS_A : i_value;
    assign high_end    = shreg[23] ? T1H_END : T0H_END;
    assign o_npxl_data = data_q;
    assign o_rdy       = rdy_q;

    always_comb begin
        peak_nxt = peak;
        hold_nxt = hold;
        if (lvl_in >= peak) begin
            peak_nxt = lvl_in;
            hold_nxt = '0;
        end else if (hold < HOLD_MAX) begin
            hold_nxt = hold + HW'(1);
        end else if (peak != '0) begin
            peak_nxt = peak - ADDR'(1);
        end
    end

    always_comb begin
        zone_rgb = {8'h00, BRIGHT, 8'h00};
        lit      = 1'b0;
        peak_hit = 1'b0;
        if (idx < YEL_A) begin
            zone_rgb = {BRIGHT, 8'h00, 8'h00};
        end else if (idx < RED_A) begin
            zone_rgb = {BRIGHT, BRIGHT, 8'h00};
        end
        if (dot_q) begin
            lit = (lvl_q != '0) && (idx == lvl_q - ADDR'(1));
        end else begin
            lit = (idx < lvl_q);
        end
        peak_hit = pe_q && (peak != '0) && (idx == peak - ADDR'(1));
        pix_word = (lit || peak_hit) ? zone_rgb : 24'h000000;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= LATCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Between pixels the LOAD cycle takes the last low clock of the previous
    // bit, so rise-to-rise spacing stays TBIT_CYC across pixel boundaries.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_send) state_nxt = LOAD;
            end
            LOAD: begin
                state_nxt = HIGH;
            end
            HIGH: begin
                if (tmr == high_end) state_nxt = LOW;
            end
            LOW: begin
                if (bit_idx != 5'd0) begin
                    if (tmr == '0) state_nxt = HIGH;
                end else if (idx == LAST_IDX) begin
                    if (tmr == '0) state_nxt = LATCH;
                end else begin
                    if (tmr == TW'(1)) state_nxt = LOAD;
                end
            end
            LATCH: begin
                if (tmr == '0) state_nxt = IDLE;
            end
            default: begin
                state_nxt = LATCH;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tmr     <= TLATCH_LD;
            bit_idx <= '0;
            shreg   <= '0;
            idx     <= '0;
            lvl_q   <= '0;
            dot_q   <= 1'b0;
            pe_q    <= 1'b0;
            peak    <= '0;
            hold    <= '0;
            data_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            data_q <= (state_nxt == HIGH);
            rdy_q  <= (state_nxt == IDLE);

            if (state_nxt == HIGH && state != HIGH) begin
                tmr <= TBIT_LD;
            end else if (state_nxt == LATCH && state != LATCH) begin
                tmr <= TLATCH_LD;
            end else if (tmr != '0) begin
                tmr <= tmr - TW'(1);
            end

            case (state)
                IDLE: begin
                    if (i_send) begin
                        lvl_q <= lvl_in;
                        dot_q <= i_dot_mode;
                        pe_q  <= i_peak_en;
                        peak  <= peak_nxt;
                        hold  <= hold_nxt;
                        idx   <= '0;
                    end
                end
                LOAD: begin
                    shreg   <= pix_word;
                    bit_idx <= 5'd23;
                end
                LOW: begin
                    if (state_nxt == HIGH) begin
                        shreg   <= {shreg[22:0], 1'b0};
                        bit_idx <= bit_idx - 5'd1;
                    end else if (state_nxt == LOAD) begin
                        idx <= idx + ADDR'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_npxl_bar_controller.sv
// Directed bench for npxl_bar_controller: decodes each serial frame back into
// 20 GRB words and checks pixel colours, bit timing, handshake and reset.
module tb_npxl_bar_controller;

    localparam int LEDS   = 20;
    localparam int T0H    = 2;
    localparam int T1H    = 4;
    localparam int TBIT   = 6;
    localparam int TLATCH = 30;

    localparam logic [23:0] GRN = 24'h200000;
    localparam logic [23:0] YEL = 24'h202000;
    localparam logic [23:0] RED = 24'h002000;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_send = 1'b0;
    logic [7:0] i_value = 8'd0;
    logic       i_dot_mode = 1'b0;
    logic       i_peak_en = 1'b0;
    logic       o_npxl_data;
    logic       o_rdy;

    int total = 0;
    int bad = 0;

    logic [23:0] pix [LEDS];
    int n1, bad_t1, bad_t0, bad_per, last_low, h_last;
    logic trunc;

    npxl_bar_controller #(
        .LEDS(LEDS), .ADDR(8), .T0H_CYC(T0H), .T1H_CYC(T1H), .TBIT_CYC(TBIT),
        .TLATCH_CYC(TLATCH), .YEL_START(12), .RED_START(16), .BRIGHT(8'h20), .PEAK_HOLD(8)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_send(i_send), .i_value(i_value),
        .i_dot_mode(i_dot_mode), .i_peak_en(i_peak_en),
        .o_npxl_data(o_npxl_data), .o_rdy(o_rdy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller is just after a posedge or at a negedge; returns at the negedge after first rise.
    task automatic send(input int v, input logic dot, input logic pe);
        int b;
        b = 0;
        @(negedge i_clk);
        while (o_rdy !== 1'b1 && b < 1000) begin
            @(negedge i_clk);
            b++;
        end
        chk("rdy_before_send", 32'(o_rdy), 1);
        i_value = 8'(v);
        i_dot_mode = dot;
        i_peak_en = pe;
        i_send = 1'b1;
        @(negedge i_clk);
        i_send = 1'b0;
        chk("rdy_drop", 32'(o_rdy), 0);
        chk("data_in_load", 32'(o_npxl_data), 0);
        @(negedge i_clk);
        chk("first_rise", 32'(o_npxl_data), 1);
    endtask

    task automatic capture();
        int h, l, b;
        logic bitv;
        trunc = 1'b0; n1 = 0; bad_t1 = 0; bad_t0 = 0; bad_per = 0; last_low = 0; h_last = 0;
        for (int p = 0; p < LEDS; p++) pix[p] = 24'h0;
        b = 0;
        while (o_npxl_data !== 1'b1 && b < 50) begin
            @(negedge i_clk);
            b++;
        end
        if (b >= 50) trunc = 1'b1;
        for (int k = 0; k < LEDS * 24 && !trunc; k++) begin
            h = 0;
            while (o_npxl_data === 1'b1 && h < 100) begin
                h++;
                @(negedge i_clk);
            end
            l = 0;
            while (o_npxl_data !== 1'b1 && o_rdy !== 1'b1 && l < 500) begin
                l++;
                @(negedge i_clk);
            end
            bitv = (h > T0H);
            if (bitv) begin
                n1++;
                if (h != T1H) bad_t1++;
            end else if (h != T0H) begin
                bad_t0++;
            end
            pix[k / 24] = {pix[k / 24][22:0], bitv};
            if (h >= 100 || l >= 500) trunc = 1'b1;
            if (k < LEDS * 24 - 1) begin
                if (h + l != TBIT) bad_per++;
                if (o_rdy === 1'b1) trunc = 1'b1;
            end else begin
                last_low = l;
                h_last = h;
                if (o_rdy !== 1'b1) trunc = 1'b1;
            end
        end
    endtask

    task automatic check_timing(input string tag);
        chk({tag, "_trunc"}, 32'(trunc), 0);
        chk({tag, "_t1h"}, 32'(bad_t1), 0);
        chk({tag, "_t0h"}, 32'(bad_t0), 0);
        chk({tag, "_tbit"}, 32'(bad_per), 0);
        chk({tag, "_latch"}, 32'(last_low + h_last), TBIT + TLATCH);
    endtask

    task automatic count_to_rdy(output int n);
        n = 0;
        do begin
            @(posedge i_clk);
            #1;
            n++;
        end while (o_rdy !== 1'b1 && n < 200);
    endtask

    initial begin
        int n, b, hi_seen, rdy_low, pk;

        // reset and latch period after release
        repeat (3) @(negedge i_clk);
        chk("reset_data", 32'(o_npxl_data), 0);
        chk("reset_rdy", 32'(o_rdy), 0);
        i_rst = 1'b0;
        count_to_rdy(n);
        chk("reset_to_rdy", 32'(n), TLATCH);

        // bar value 3
        send(3, 1'b0, 1'b0);
        capture();
        check_timing("v3");
        chk("v3_pix0", 32'(pix[0]), GRN);
        chk("v3_pix2", 32'(pix[2]), GRN);
        chk("v3_pix3", 32'(pix[3]), 0);
        chk("v3_pix19", 32'(pix[19]), 0);
        chk("v3_ones", 32'(n1), 3);

        // zone colours at 17, clamp at 25
        send(17, 1'b0, 1'b0);
        capture();
        check_timing("v17");
        chk("v17_pix11", 32'(pix[11]), GRN);
        chk("v17_pix12", 32'(pix[12]), YEL);
        chk("v17_pix15", 32'(pix[15]), YEL);
        chk("v17_pix16", 32'(pix[16]), RED);
        chk("v17_pix17", 32'(pix[17]), 0);
        chk("v17_ones", 32'(n1), 21);

        send(25, 1'b0, 1'b0);
        capture();
        check_timing("v25");
        chk("v25_pix0", 32'(pix[0]), GRN);
        chk("v25_pix15", 32'(pix[15]), YEL);
        chk("v25_pix16", 32'(pix[16]), RED);
        chk("v25_pix19", 32'(pix[19]), RED);
        chk("v25_ones", 32'(n1), 24);

        // dot mode
        send(11, 1'b1, 1'b0);
        capture();
        check_timing("dot11");
        chk("dot11_pix9", 32'(pix[9]), 0);
        chk("dot11_pix10", 32'(pix[10]), GRN);
        chk("dot11_pix11", 32'(pix[11]), 0);
        chk("dot11_ones", 32'(n1), 1);

        send(0, 1'b1, 1'b0);
        capture();
        check_timing("dot0");
        chk("dot0_ones", 32'(n1), 0);

        // i_send mid-frame is ignored and not queued
        send(5, 1'b0, 1'b0);
        fork
            capture();
            begin
                repeat (200) @(negedge i_clk);
                i_value = 8'd20;
                i_send = 1'b1;
                @(negedge i_clk);
                i_send = 1'b0;
            end
        join
        check_timing("ign");
        chk("ign_pix4", 32'(pix[4]), GRN);
        chk("ign_pix5", 32'(pix[5]), 0);
        hi_seen = 0;
        rdy_low = 0;
        repeat (20) begin
            @(negedge i_clk);
            if (o_npxl_data !== 1'b0) hi_seen++;
            if (o_rdy !== 1'b1) rdy_low++;
        end
        chk("ign_no_queue_data", 32'(hi_seen), 0);
        chk("ign_no_queue_rdy", 32'(rdy_low), 0);

        // reset mid-frame
        send(9, 1'b0, 1'b0);
        repeat (100) @(negedge i_clk);
        b = 0;
        while (o_npxl_data !== 1'b1 && b < 20) begin
            @(negedge i_clk);
            b++;
        end
        chk("mid_rst_pre_high", 32'(o_npxl_data), 1);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        chk("mid_rst_data", 32'(o_npxl_data), 0);
        chk("mid_rst_rdy", 32'(o_rdy), 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        count_to_rdy(n);
        chk("mid_rst_to_rdy", 32'(n), TLATCH);

        // peak hold and decay (peak cleared by the reset above)
        send(15, 1'b0, 1'b1);
        capture();
        check_timing("pk0");
        chk("pk0_pix14", 32'(pix[14]), YEL);
        chk("pk0_pix15", 32'(pix[15]), 0);
        chk("pk0_ones", 32'(n1), 18);
        for (int f = 1; f <= 10; f++) begin
            send(2, 1'b0, 1'b1);
            capture();
            check_timing($sformatf("pk%0d", f));
            pk = (f <= 8) ? 14 : (f == 9) ? 13 : 12;
            chk($sformatf("pk%0d_peak_pix", f), 32'(pix[pk]), YEL);
            chk($sformatf("pk%0d_above_peak", f), 32'(pix[pk + 1]), 0);
            chk($sformatf("pk%0d_pix1", f), 32'(pix[1]), GRN);
            chk($sformatf("pk%0d_ones", f), 32'(n1), 4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
